// File: rtl/vanilla_scoreboard_multi_tracker.sv
// Per-bank, per-register pending-op tracker with op-class bits, ages, totals and sticky error flags.
// Define VANILLA_SCOREBOARD_MULTI_TRACKER_TIMEOUT_EN to build the per-entry timeout reporter.
module vanilla_scoreboard_multi_tracker #(
    parameter int banks_p           = 2,
    parameter int reg_els_p         = 32,
    parameter int num_classes_p     = 8,
    parameter int max_outstanding_p = 1,
    parameter int age_width_p       = 16,
    parameter int timeout_cycles_p  = 1000,
    parameter int reg_addr_width_lp = (reg_els_p <= 1) ? 1 : $clog2(reg_els_p),
    parameter int class_width_lp    = (num_classes_p <= 1) ? 1 : $clog2(num_classes_p),
    parameter int cnt_width_lp      = $clog2(max_outstanding_p + 1),
    parameter int total_width_lp    = $clog2(reg_els_p * max_outstanding_p + 1),
    parameter int bank_width_lp     = (banks_p <= 1) ? 1 : $clog2(banks_p)
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,
    input  logic                                        flush_i,
    input  logic                                        stall_all_i,
    input  logic                                        stall_id_i,
    input  logic [banks_p-1:0]                          set_v_i,
    input  logic [banks_p*reg_addr_width_lp-1:0]        set_reg_i,
    input  logic [banks_p*class_width_lp-1:0]           set_class_i,
    input  logic [banks_p-1:0]                          clear_v_i,
    input  logic [banks_p*reg_addr_width_lp-1:0]        clear_reg_i,
    output logic [banks_p*reg_els_p*num_classes_p-1:0]  sb_class_o,
    output logic [banks_p*reg_els_p-1:0]                sb_busy_o,
    output logic [banks_p*total_width_lp-1:0]           pending_total_o,
    output logic [banks_p*age_width_p-1:0]              oldest_age_o,
    output logic                                        timeout_v_o,
    output logic [bank_width_lp-1:0]                    timeout_bank_o,
    output logic [reg_addr_width_lp-1:0]                timeout_reg_o,
    output logic                                        overflow_err_o,
    output logic                                        underflow_err_o
);
    localparam int entries_lp = banks_p * reg_els_p;

    logic [banks_p-1:0]      w_set_eff;
    logic [cnt_width_lp-1:0] w_cnt [entries_lp];
    logic [age_width_p-1:0]  w_age [entries_lp];
    logic [entries_lp-1:0]   w_ovf;
    logic [entries_lp-1:0]   w_unf;
    logic                    r_overflow;
    logic                    r_underflow;
`ifdef VANILLA_SCOREBOARD_MULTI_TRACKER_TIMEOUT_EN
    logic [entries_lp-1:0]        w_pend;
    logic [entries_lp-1:0]        w_sel;
    logic                         w_sel_v;
    logic [bank_width_lp-1:0]     w_sel_bank;
    logic [reg_addr_width_lp-1:0] w_sel_reg;
`endif

    // Only issue is gated by pipeline control; completions always land.
    assign w_set_eff = set_v_i & ~{banks_p{stall_id_i | stall_all_i | flush_i}};

    for (genvar b = 0; b < banks_p; b++) begin : g_bank
        for (genvar r = 0; r < reg_els_p; r++) begin : g_reg
            localparam int idx_lp = b * reg_els_p + r;
            logic                     w_set, w_clr, w_ovf_e, w_unf_e;
            logic [cnt_width_lp-1:0]  r_cnt, w_cnt_n;
            logic [num_classes_p-1:0] r_class, w_class_n, w_onehot;
            logic [age_width_p-1:0]   r_age, w_age_n, w_age_inc;

            assign w_set = w_set_eff[b] &&
                (set_reg_i[b*reg_addr_width_lp +: reg_addr_width_lp] == reg_addr_width_lp'(r));
            assign w_clr = clear_v_i[b] &&
                (clear_reg_i[b*reg_addr_width_lp +: reg_addr_width_lp] == reg_addr_width_lp'(r));
            assign w_onehot  = num_classes_p'(1) << set_class_i[b*class_width_lp +: class_width_lp];
            assign w_age_inc = (r_age == '1) ? r_age : r_age + age_width_p'(1);

            always_comb begin
                w_cnt_n   = r_cnt;
                w_class_n = r_class;
                w_age_n   = (r_cnt != '0) ? w_age_inc : '0;
                w_ovf_e   = 1'b0;
                w_unf_e   = 1'b0;
                if (w_set && w_clr) begin
                    // Issue and completion cancel; an idle entry stays idle with no class.
                    w_age_n = '0;
                    if (r_cnt != '0) w_class_n = r_class | w_onehot;
                end else if (w_set) begin
                    w_class_n = r_class | w_onehot;
                    if (r_cnt == cnt_width_lp'(max_outstanding_p)) w_ovf_e = 1'b1;
                    else w_cnt_n = r_cnt + cnt_width_lp'(1);
                end else if (w_clr) begin
                    w_age_n = '0;
                    if (r_cnt == '0) begin
                        w_unf_e = 1'b1;
                    end else begin
                        w_cnt_n = r_cnt - cnt_width_lp'(1);
                        if (r_cnt == cnt_width_lp'(1)) w_class_n = '0;
                    end
                end
            end

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_cnt   <= '0;
                    r_class <= '0;
                    r_age   <= '0;
                end else begin
                    r_cnt   <= w_cnt_n;
                    r_class <= w_class_n;
                    r_age   <= w_age_n;
                end
            end

`ifdef VANILLA_SCOREBOARD_MULTI_TRACKER_TIMEOUT_EN
            logic r_pend;
            // Armed only on the edge the age reaches the threshold, so a saturated age never re-arms.
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) r_pend <= 1'b0;
                else r_pend <= (w_cnt_n != '0) &&
                    ((r_pend && !w_sel[idx_lp]) ||
                     ((w_age_n == age_width_p'(timeout_cycles_p)) &&
                      (r_age != age_width_p'(timeout_cycles_p))));
            end
            assign w_pend[idx_lp] = r_pend;
`endif

            assign w_cnt[idx_lp] = r_cnt;
            assign w_age[idx_lp] = r_age;
            assign w_ovf[idx_lp] = w_ovf_e;
            assign w_unf[idx_lp] = w_unf_e;
            assign sb_busy_o[idx_lp] = (r_cnt != '0);
            assign sb_class_o[idx_lp*num_classes_p +: num_classes_p] = r_class;
        end
    end

    always_comb begin
        pending_total_o = '0;
        oldest_age_o    = '0;
        for (int b = 0; b < banks_p; b++) begin
            for (int r = 0; r < reg_els_p; r++) begin
                pending_total_o[b*total_width_lp +: total_width_lp] += total_width_lp'(w_cnt[b*reg_els_p + r]);
                if (w_age[b*reg_els_p + r] > oldest_age_o[b*age_width_p +: age_width_p])
                    oldest_age_o[b*age_width_p +: age_width_p] = w_age[b*reg_els_p + r];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= r_overflow  | (|w_ovf);
            r_underflow <= r_underflow | (|w_unf);
        end
    end
    assign overflow_err_o  = r_overflow;
    assign underflow_err_o = r_underflow;

`ifdef VANILLA_SCOREBOARD_MULTI_TRACKER_TIMEOUT_EN
    // Descending scan so the lowest bank/register index wins.
    always_comb begin
        w_sel      = '0;
        w_sel_v    = 1'b0;
        w_sel_bank = '0;
        w_sel_reg  = '0;
        for (int i = entries_lp - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_sel      = '0;
                w_sel[i]   = 1'b1;
                w_sel_v    = 1'b1;
                w_sel_bank = bank_width_lp'(i / reg_els_p);
                w_sel_reg  = reg_addr_width_lp'(i % reg_els_p);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            timeout_v_o    <= 1'b0;
            timeout_bank_o <= '0;
            timeout_reg_o  <= '0;
        end else begin
            timeout_v_o    <= w_sel_v;
            timeout_bank_o <= w_sel_bank;
            timeout_reg_o  <= w_sel_reg;
        end
    end
`else
    assign timeout_v_o    = 1'b0;
    assign timeout_bank_o = '0;
    assign timeout_reg_o  = '0;
`endif

endmodule

// File: tb/tb_vanilla_scoreboard_multi_tracker.sv
// Self-checking bench for vanilla_scoreboard_multi_tracker: directed table, corner sequences, random vs model.
`timescale 1ns/1ps
module tb_vanilla_scoreboard_multi_tracker;
    localparam int BANKS = 2, REGS = 32, NCLS = 8, MAXO = 2, AW = 5, TO = 10;
    localparam int RAW = 5, CW = 3, TW = 7, BW = 1;
    localparam int AGE_MAX = (1 << AW) - 1;
`ifdef VANILLA_SCOREBOARD_MULTI_TRACKER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset_n_i, flush_i, stall_all_i, stall_id_i;
    logic [BANKS-1:0]          set_v_i, clear_v_i;
    logic [BANKS*RAW-1:0]      set_reg_i, clear_reg_i;
    logic [BANKS*CW-1:0]       set_class_i;
    logic [BANKS*REGS*NCLS-1:0] sb_class_o;
    logic [BANKS*REGS-1:0]     sb_busy_o;
    logic [BANKS*TW-1:0]       pending_total_o;
    logic [BANKS*AW-1:0]       oldest_age_o;
    logic                      timeout_v_o;
    logic [BW-1:0]             timeout_bank_o;
    logic [RAW-1:0]            timeout_reg_o;
    logic                      overflow_err_o, underflow_err_o;

    vanilla_scoreboard_multi_tracker #(
        .banks_p(BANKS), .reg_els_p(REGS), .num_classes_p(NCLS),
        .max_outstanding_p(MAXO), .age_width_p(AW), .timeout_cycles_p(TO)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .flush_i(flush_i), .stall_all_i(stall_all_i),
        .stall_id_i(stall_id_i), .set_v_i(set_v_i), .set_reg_i(set_reg_i), .set_class_i(set_class_i),
        .clear_v_i(clear_v_i), .clear_reg_i(clear_reg_i), .sb_class_o(sb_class_o), .sb_busy_o(sb_busy_o),
        .pending_total_o(pending_total_o), .oldest_age_o(oldest_age_o), .timeout_v_o(timeout_v_o),
        .timeout_bank_o(timeout_bank_o), .timeout_reg_o(timeout_reg_o),
        .overflow_err_o(overflow_err_o), .underflow_err_o(underflow_err_o)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: outstanding count, class set and age per register, plus pending-timeout set.
    int              m_cnt [BANKS][REGS];
    logic [NCLS-1:0] m_cls [BANKS][REGS];
    int              m_age [BANKS][REGS];
    bit              m_pend[BANKS][REGS];
    bit              m_ovf, m_unf, m_to_v;
    int              m_to_b, m_to_r;

    typedef struct {
        logic [1:0] sv; int sreg; int scls; logic [1:0] cv; int creg;
        bit sid; bit sall; bit fl;
        int wb; int wr; bit e_busy; logic [7:0] e_cls; int e_t0; int e_t1; int e_age; bit e_ovf; bit e_unf;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] sv, int sreg, int scls, logic [1:0] cv, int creg,
                                bit sid, bit sall, bit fl, int wb, int wr, bit eb, logic [7:0] ec,
                                int t0, int t1, int ea, bit eo, bit eu);
        vec_t v;
        v.sv = sv; v.sreg = sreg; v.scls = scls; v.cv = cv; v.creg = creg;
        v.sid = sid; v.sall = sall; v.fl = fl; v.wb = wb; v.wr = wr;
        v.e_busy = eb; v.e_cls = ec; v.e_t0 = t0; v.e_t1 = t1; v.e_age = ea; v.e_ovf = eo; v.e_unf = eu;
        return v;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < BANKS; b++)
            for (int r = 0; r < REGS; r++) begin
                m_cnt[b][r] = 0; m_cls[b][r] = '0; m_age[b][r] = 0; m_pend[b][r] = 0;
            end
        m_ovf = 0; m_unf = 0; m_to_v = 0; m_to_b = 0; m_to_r = 0;
    endtask

    task automatic model_step();
        bit gate, s, c;
        int n, old_age, cls;
        gate = !stall_id_i && !stall_all_i && !flush_i;
        m_to_v = 0; m_to_b = 0; m_to_r = 0;
        if (TO_EN)
            for (int b = 0; b < BANKS; b++)
                for (int r = 0; r < REGS; r++)
                    if (!m_to_v && m_pend[b][r]) begin
                        m_to_v = 1; m_to_b = b; m_to_r = r; m_pend[b][r] = 0;
                    end
        for (int b = 0; b < BANKS; b++) begin
            for (int r = 0; r < REGS; r++) begin
                s = gate && set_v_i[b] && (int'(set_reg_i[b*RAW +: RAW]) == r);
                c = clear_v_i[b] && (int'(clear_reg_i[b*RAW +: RAW]) == r);
                cls = int'(set_class_i[b*CW +: CW]);
                n = m_cnt[b][r];
                old_age = m_age[b][r];
                if (s) m_cls[b][r][cls] = 1'b1;
                if (s && !c) begin
                    if (n == MAXO) m_ovf = 1; else m_cnt[b][r] = n + 1;
                end else if (c && !s) begin
                    if (n == 0) m_unf = 1; else m_cnt[b][r] = n - 1;
                end
                if (m_cnt[b][r] == 0) m_cls[b][r] = '0;
                if (m_cnt[b][r] == 0 || c || n == 0) m_age[b][r] = 0;
                else m_age[b][r] = (old_age + 1 > AGE_MAX) ? AGE_MAX : old_age + 1;
                if (m_cnt[b][r] == 0) m_pend[b][r] = 0;
                else if (TO_EN && old_age != TO && m_age[b][r] == TO) m_pend[b][r] = 1;
            end
        end
    endtask

    task automatic check_all();
        logic [BANKS*REGS*NCLS-1:0] e_cls;
        logic [BANKS*REGS-1:0]      e_busy;
        logic [BANKS*TW-1:0]        e_tot;
        logic [BANKS*AW-1:0]        e_age;
        int tot, mx, idx;
        for (int b = 0; b < BANKS; b++) begin
            tot = 0; mx = 0;
            for (int r = 0; r < REGS; r++) begin
                idx = b * REGS + r;
                e_cls[idx*NCLS +: NCLS] = m_cls[b][r];
                e_busy[idx] = (m_cnt[b][r] != 0);
                tot += m_cnt[b][r];
                if (m_age[b][r] > mx) mx = m_age[b][r];
            end
            e_tot[b*TW +: TW] = TW'(tot);
            e_age[b*AW +: AW] = AW'(mx);
        end
        chk("sb_class", sb_class_o, e_cls);
        chk("sb_busy", sb_busy_o, e_busy);
        chk("pending_total", pending_total_o, e_tot);
        chk("oldest_age", oldest_age_o, e_age);
        chk("overflow_err", overflow_err_o, m_ovf);
        chk("underflow_err", underflow_err_o, m_unf);
        chk("timeout_v", timeout_v_o, m_to_v);
        if (m_to_v) begin
            chk("timeout_bank", timeout_bank_o, m_to_b);
            chk("timeout_reg", timeout_reg_o, m_to_r);
        end
    endtask

    task automatic idle_inputs();
        set_v_i = '0; set_reg_i = '0; set_class_i = '0; clear_v_i = '0; clear_reg_i = '0;
        stall_id_i = 0; stall_all_i = 0; flush_i = 0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n_i = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset_n_i = 1;
    endtask

    initial begin
        vec_t v;
        int idx, n_rep;

        idle_inputs();
        reset_n_i = 0;
        model_reset();
        tbl.push_back(mk(2'b01, 5, 2, 2'b00, 0, 0,0,0, 0, 5, 1, 8'h04, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b00, 0, 0,0,0, 0, 5, 1, 8'h04, 1, 0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b00, 0, 0,0,0, 0, 5, 1, 8'h04, 1, 0, 2, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b00, 0, 0,0,0, 0, 5, 1, 8'h04, 1, 0, 3, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b01, 5, 0,0,0, 0, 5, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b10, 7, 1, 2'b00, 0, 1,0,0, 1, 7, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b10, 7, 1, 2'b00, 0, 0,0,1, 1, 7, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b10, 7, 1, 2'b00, 0, 0,1,0, 1, 7, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b10, 7, 1, 2'b00, 0, 0,0,0, 1, 7, 1, 8'h02, 0, 1, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b00, 0, 0,0,0, 0, 7, 0, 8'h00, 0, 1, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b10, 7, 0,0,0, 1, 7, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 9, 0, 2'b00, 0, 0,0,0, 0, 9, 1, 8'h01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 9, 1, 2'b01, 9, 0,0,0, 0, 9, 1, 8'h03, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b01, 9, 0,0,0, 0, 9, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01,11, 5, 2'b01,11, 0,0,0, 0,11, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 3, 0, 2'b00, 0, 0,0,0, 0, 3, 1, 8'h01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 3, 4, 2'b00, 0, 0,0,0, 0, 3, 1, 8'h11, 2, 0, 1, 0, 0));
        tbl.push_back(mk(2'b01, 3, 4, 2'b00, 0, 0,0,0, 0, 3, 1, 8'h11, 2, 0, 2, 1, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b01, 3, 0,0,0, 0, 3, 1, 8'h11, 1, 0, 0, 1, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b01, 3, 0,0,0, 0, 3, 0, 8'h00, 0, 0, 0, 1, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b01, 3, 0,0,0, 0, 3, 0, 8'h00, 0, 0, 0, 1, 1));

        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset_n_i = 1;

        foreach (tbl[i]) begin
            v = tbl[i];
            set_v_i = v.sv; set_reg_i = {RAW'(v.sreg), RAW'(v.sreg)}; set_class_i = {CW'(v.scls), CW'(v.scls)};
            clear_v_i = v.cv; clear_reg_i = {RAW'(v.creg), RAW'(v.creg)};
            stall_id_i = v.sid; stall_all_i = v.sall; flush_i = v.fl;
            cycle();
            idx = v.wb * REGS + v.wr;
            chk($sformatf("row%0d busy", i), sb_busy_o[idx], v.e_busy);
            chk($sformatf("row%0d class", i), sb_class_o[idx*NCLS +: NCLS], v.e_cls);
            chk($sformatf("row%0d total0", i), pending_total_o[0 +: TW], v.e_t0);
            chk($sformatf("row%0d total1", i), pending_total_o[TW +: TW], v.e_t1);
            chk($sformatf("row%0d age", i), oldest_age_o[v.wb*AW +: AW], v.e_age);
            chk($sformatf("row%0d ovf", i), overflow_err_o, v.e_ovf);
            chk($sformatf("row%0d unf", i), underflow_err_o, v.e_unf);
        end

        // Timeout ordering: both banks cross the threshold together, bank 0 reports first.
        do_reset();
        set_v_i = 2'b11; set_reg_i = {5'd2, 5'd2};
        cycle();
        idle_inputs();
        n_rep = 0;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (timeout_v_o) n_rep++;
            chk($sformatf("to_v k=%0d", k), timeout_v_o, TO_EN && (k == 11 || k == 12));
            if (TO_EN && (k == 11 || k == 12)) begin
                chk($sformatf("to_bank k=%0d", k), timeout_bank_o, (k == 12) ? 1 : 0);
                chk($sformatf("to_reg k=%0d", k), timeout_reg_o, 2);
            end
        end
        chk("to_report_count", n_rep, TO_EN ? 2 : 0);
        chk("age_saturated", oldest_age_o[0 +: AW], AGE_MAX);

        // Asynchronous reset in the middle of a cycle with five entries outstanding.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_v_i = (k == 2) ? 2'b01 : 2'b11;
            set_reg_i = {RAW'(k + 1), RAW'(k + 1)};
            set_class_i = {CW'(k), CW'(k + 3)};
            cycle();
        end
        idle_inputs();
        chk("busy_before_reset", $countones(sb_busy_o), 5);
        #2;
        reset_n_i = 0;
        #1;
        model_reset();
        chk("async_busy", sb_busy_o, 0);
        chk("async_class", sb_class_o, 0);
        chk("async_total", pending_total_o, 0);
        check_all();
        @(posedge clk);
        #1;
        reset_n_i = 1;
        clear_v_i = 2'b01; clear_reg_i = {5'd0, 5'd1};
        cycle();
        chk("post_reset_underflow", underflow_err_o, 1'b1);

        // Random traffic on a few hot registers; second half clears rarely so ages and overflow build up.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            int hi;
            hi = ($urandom_range(0, 7) == 0) ? REGS - 1 : 3;
            set_v_i = BANKS'($urandom_range(0, 3));
            set_reg_i = {RAW'($urandom_range(0, hi)), RAW'($urandom_range(0, hi))};
            set_class_i = {CW'($urandom_range(0, NCLS - 1)), CW'($urandom_range(0, NCLS - 1))};
            clear_v_i[0] = ($urandom_range(0, (k < 750) ? 1 : 7) == 0);
            clear_v_i[1] = ($urandom_range(0, (k < 750) ? 1 : 7) == 0);
            clear_reg_i = {RAW'($urandom_range(0, hi)), RAW'($urandom_range(0, hi))};
            stall_id_i = ($urandom_range(0, 7) == 0);
            stall_all_i = ($urandom_range(0, 9) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
